// File: rtl/DH_pkg.sv
// Shared types and constants for the Duck Hunt game loop.
//   round_state_t      : states of the round sequencer (ctl_round)
//   AMMO_QUANTITY      : shots per reload, owned by the ammo counter
//   *_DEFAULT          : default timing/round parameters for ctl_round
//   max3()             : helper used to size timers from several cycle counts
package DH_pkg;

  localparam int AMMO_QUANTITY            = 3;

  localparam int ROUNDS_DEFAULT           = 5;
  localparam int HIT_WINDOW_DEFAULT       = 4;
  localparam int RELOAD_CYCLES_DEFAULT    = 3;
  localparam int ROUND_END_CYCLES_DEFAULT = 3;

  localparam int HITS_MAX                 = 99;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RELOAD    = 3'd1,
    ST_ARMED     = 3'd2,
    ST_HIT_WIN   = 3'd3,
    ST_ROUND_END = 3'd4,
    ST_GAME_OVER = 3'd5
  } round_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ammo_counter.sv
// Ammo counter for the Duck Hunt game loop.
// Holds the remaining shots, reloads to AMMO_QUANTITY on reset_score and
// decrements once per shot_fired pulse, stopping at zero.
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset (reloads to full)
//   shot_fired  in   one-cycle pulse per accepted shot
//   reset_score in   one-cycle reload pulse
//   no_ammo     out  high while the counter is empty
//   ammo        out  remaining shots
import DH_pkg::*;

module ammo_counter #(
  parameter int AMMO_QUANTITY_P = AMMO_QUANTITY,
  localparam int AW = $clog2(AMMO_QUANTITY_P + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shot_fired,
  input  logic          reset_score,
  output logic          no_ammo,
  output logic [AW-1:0] ammo
);

  localparam logic [AW-1:0] AMMO_FULL = AW'(AMMO_QUANTITY_P);

  always_ff @(posedge clk) begin
    if (rst) begin
      ammo <= AMMO_FULL;
    end else if (reset_score) begin
      ammo <= AMMO_FULL;
    end else if (shot_fired && (ammo != '0)) begin
      ammo <= ammo - 1'b1;
    end
  end

  // Decoded straight from the register so it is valid the cycle after the
  // decrement edge.
  assign no_ammo = (ammo == '0);

endmodule

// File: rtl/ctl_round.sv
// Round sequencer for the Duck Hunt game loop.
// Reloads the ammo counter at the start of every round, turns trigger
// rising edges into shot pulses while armed, scores at most one hit per
// shot inside a short hit window, and steps through ROUNDS rounds before
// holding in game over until the next start edge.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   start      in   start/restart button level (rising edge used)
//   trigger    in   gun trigger level (rising edge used)
//   hit        in   duck-hit flag, only scored inside the hit window
//   no_ammo    in   empty flag from the ammo counter
//   shot_fired out  one-cycle pulse per accepted shot
//   reset_ammo out  one-cycle reload pulse to the ammo counter
//   armed      out  high while waiting for a shot
//   game_over  out  high while the game has finished
//   round_num  out  current round 1..ROUNDS, 0 before the first game
//   hits       out  hits this game, saturating at 99
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | after reset, waiting for the first start edge
// ST_RELOAD    | ammo reload pulse issued, counting RELOAD_CYCLES
// ST_ARMED     | accepting trigger edges while ammo remains
// ST_HIT_WIN   | shot taken, scoring the first hit within HIT_WINDOW
// ST_ROUND_END | out of ammo, pause of ROUND_END_CYCLES before next round
// ST_GAME_OVER | all rounds played, results held until a start edge
import DH_pkg::*;

module ctl_round #(
  parameter int ROUNDS           = ROUNDS_DEFAULT,
  parameter int HIT_WINDOW       = HIT_WINDOW_DEFAULT,
  parameter int RELOAD_CYCLES    = RELOAD_CYCLES_DEFAULT,
  parameter int ROUND_END_CYCLES = ROUND_END_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       trigger,
  input  logic       hit,
  input  logic       no_ammo,
  output logic       shot_fired,
  output logic       reset_ammo,
  output logic       armed,
  output logic       game_over,
  output logic [3:0] round_num,
  output logic [6:0] hits
);

  localparam int TMAX = max3(HIT_WINDOW, RELOAD_CYCLES, ROUND_END_CYCLES);
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] T_RELOAD    = TW'(RELOAD_CYCLES - 1);
  localparam logic [TW-1:0] T_HIT_WIN   = TW'(HIT_WINDOW - 1);
  localparam logic [TW-1:0] T_ROUND_END = TW'(ROUND_END_CYCLES - 1);
  localparam logic [6:0]    HITS_SAT    = 7'(HITS_MAX);
  localparam logic [3:0]    ROUND_LAST  = 4'(ROUNDS);

  round_state_t  state;
  logic [TW-1:0] timer;
  logic          start_last;
  logic          trig_last;

  logic start_edge;
  logic trig_edge;
  logic timer_done;

  assign start_edge = start & ~start_last;
  assign trig_edge  = trigger & ~trig_last;
  assign timer_done = (timer == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      timer      <= '0;
      start_last <= 1'b0;
      trig_last  <= 1'b0;
      shot_fired <= 1'b0;
      reset_ammo <= 1'b0;
      armed      <= 1'b0;
      game_over  <= 1'b0;
      round_num  <= '0;
      hits       <= '0;
    end else begin
      start_last <= start;
      trig_last  <= trigger;
      shot_fired <= 1'b0;
      reset_ammo <= 1'b0;

      unique case (state)
        ST_IDLE, ST_GAME_OVER: begin
          if (start_edge) begin
            round_num  <= 4'd1;
            hits       <= '0;
            timer      <= T_RELOAD;
            reset_ammo <= 1'b1;
            game_over  <= 1'b0;
            state      <= ST_RELOAD;
          end
        end

        ST_RELOAD: begin
          if (timer_done) begin
            armed <= 1'b1;
            state <= ST_ARMED;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        ST_ARMED: begin
          // Empty magazine wins over a simultaneous trigger edge.
          if (no_ammo) begin
            timer <= T_ROUND_END;
            armed <= 1'b0;
            state <= ST_ROUND_END;
          end else if (trig_edge) begin
            shot_fired <= 1'b1;
            timer      <= T_HIT_WIN;
            armed      <= 1'b0;
            state      <= ST_HIT_WIN;
          end
        end

        ST_HIT_WIN: begin
          if (hit && (hits != HITS_SAT)) begin
            hits <= hits + 1'b1;
          end
          // A hit closes the window, so only one hit is scored per shot;
          // hit and expiry together still exit just once.
          if (hit || timer_done) begin
            if (no_ammo) begin
              timer <= T_ROUND_END;
              state <= ST_ROUND_END;
            end else begin
              armed <= 1'b1;
              state <= ST_ARMED;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        ST_ROUND_END: begin
          if (timer_done) begin
            if (round_num == ROUND_LAST) begin
              game_over <= 1'b1;
              state     <= ST_GAME_OVER;
            end else begin
              round_num  <= round_num + 1'b1;
              timer      <= T_RELOAD;
              reset_ammo <= 1'b1;
              state      <= ST_RELOAD;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: begin
          armed     <= 1'b0;
          game_over <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
